// File: rtl/optical_switch_driver_pkg.sv
`default_nettype none
// optical_switch_driver_pkg: shared optical-control states, switch constants and helpers.
// Rev 1.0
package optical_switch_driver_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    LATCH  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } osd_state_e;

  localparam logic P_BAR   = 1'b0;
  localparam logic P_CROSS = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/optical_sclk_gen.sv
`default_nettype none
// optical_sclk_gen: divided serial clock plus a strobe on the last cycle of each bit.
// Rev 1.0
module optical_sclk_gen #(
  parameter int P_CLKDIV = 2,
  parameter int P_CNT_W  = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_bit_adv
);

  localparam logic [P_CNT_W-1:0] C_HALF_LAST = P_CNT_W'(P_CLKDIV - 1);

  logic [P_CNT_W-1:0] phase_q, phase_d;
  logic               sclk_q, sclk_d;

  // Disabled generator parks low with phase cleared so each transfer starts on a low half.
  always_comb begin
    phase_d = '0;
    sclk_d  = 1'b0;
    if (i_en) begin
      if (phase_q == C_HALF_LAST) begin
        phase_d = '0;
        sclk_d  = ~sclk_q;
      end else begin
        phase_d = phase_q + P_CNT_W'(1);
        sclk_d  = sclk_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q <= '0;
      sclk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
    end
  end

  assign o_sclk    = sclk_q;
  assign o_bit_adv = i_en & sclk_q & (phase_q == C_HALF_LAST);

endmodule
`default_nettype wire

// File: rtl/optical_switch_driver.sv
`default_nettype none
// optical_switch_driver: serialises switch-config words, latches them and waits for optical settle.
// Rev 1.0
module optical_switch_driver
  import optical_switch_driver_pkg::*;
#(
  parameter int P_GRANTWIDTH    = 20,
  parameter int P_CLKDIV        = 2,
  parameter int P_LATCH_CYCLES  = 2,
  parameter int P_SETTLE_CYCLES = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_GRANTWIDTH-1:0] i_grant,
  input  logic                    i_grant_valid,
  output logic                    o_sw_sclk,
  output logic                    o_sw_sdata,
  output logic                    o_sw_latch,
  output logic                    o_busy,
  output logic                    o_config_done,
  output logic [P_GRANTWIDTH-1:0] o_applied_grant,
  output logic                    o_overwrite
);

  localparam int C_BIT_W = (P_GRANTWIDTH > 1) ? $clog2(P_GRANTWIDTH) : 1;
  localparam int C_CNT_W = $clog2(max3(P_CLKDIV, P_LATCH_CYCLES, P_SETTLE_CYCLES) + 1);
  localparam logic [C_BIT_W-1:0] C_LAST_BIT    = C_BIT_W'(P_GRANTWIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_LATCH_LAST  = C_CNT_W'(P_LATCH_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_SETTLE_LAST = C_CNT_W'(P_SETTLE_CYCLES - 1);

  osd_state_e              state_q, state_d;
  logic [P_GRANTWIDTH-1:0] shift_q, shift_d;
  logic [P_GRANTWIDTH-1:0] word_q, word_d;
  logic [P_GRANTWIDTH-1:0] pend_q, pend_d;
  logic                    pend_full_q, pend_full_d;
  logic [C_BIT_W-1:0]      bit_q, bit_d;
  logic [C_CNT_W-1:0]      cnt_q, cnt_d;
  logic [P_GRANTWIDTH-1:0] applied_q, applied_d;
  logic                    ovw_q, ovw_d;
  logic                    busy_q, latch_q, done_q;
  logic                    w_launch;
  logic [P_GRANTWIDTH-1:0] w_launch_word;
  logic                    w_bit_adv;
  logic                    w_sclk;

  optical_sclk_gen #(
    .P_CLKDIV (P_CLKDIV),
    .P_CNT_W  (C_CNT_W)
  ) u_sclk_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (state_q == SHIFT),
    .o_sclk    (w_sclk),
    .o_bit_adv (w_bit_adv)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    word_d        = word_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    bit_d         = bit_q;
    cnt_d         = cnt_q;
    applied_d     = applied_q;
    ovw_d         = 1'b0;
    w_launch      = 1'b0;
    w_launch_word = '0;

    if (i_grant_valid && state_q != IDLE && state_q != DONE) begin
      pend_d      = i_grant;
      pend_full_d = 1'b1;
      ovw_d       = pend_full_q;
    end

    case (state_q)
      IDLE: begin
        if (i_grant_valid) begin
          w_launch      = 1'b1;
          w_launch_word = i_grant;
        end
      end
      SHIFT: begin
        if (w_bit_adv) begin
          shift_d = shift_q << 1;
          if (bit_q == C_LAST_BIT) begin
            bit_d   = '0;
            state_d = LATCH;
          end else begin
            bit_d = bit_q + C_BIT_W'(1);
          end
        end
      end
      LATCH: begin
        if (cnt_q == C_LATCH_LAST) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_q == C_SETTLE_LAST) begin
          cnt_d     = '0;
          state_d   = DONE;
          applied_d = word_q;
        end else begin
          cnt_d = cnt_q + C_CNT_W'(1);
        end
      end
      DONE: begin
        // A word arriving in DONE supersedes any pending one and launches immediately.
        if (i_grant_valid) begin
          w_launch      = 1'b1;
          w_launch_word = i_grant;
          ovw_d         = pend_full_q;
          pend_full_d   = 1'b0;
        end else if (pend_full_q) begin
          w_launch      = 1'b1;
          w_launch_word = pend_q;
          pend_full_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_launch) begin
      state_d = SHIFT;
      shift_d = w_launch_word;
      word_d  = w_launch_word;
      bit_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      word_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      bit_q       <= '0;
      cnt_q       <= '0;
      applied_q   <= '0;
      ovw_q       <= 1'b0;
      busy_q      <= 1'b0;
      latch_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      applied_q   <= applied_d;
      ovw_q       <= ovw_d;
      busy_q      <= (state_d != IDLE);
      latch_q     <= (state_d == LATCH);
      done_q      <= (state_d == DONE);
    end
  end

  assign o_sw_sclk       = w_sclk;
  assign o_sw_sdata      = shift_q[P_GRANTWIDTH-1];
  assign o_sw_latch      = latch_q;
  assign o_busy          = busy_q;
  assign o_config_done   = done_q;
  assign o_applied_grant = applied_q;
  assign o_overwrite     = ovw_q;

endmodule
`default_nettype wire

// File: tb/tb_optical_switch_driver.sv
`default_nettype none
// tb_optical_switch_driver: directed scenarios for the optical switch driver.
// Rev 1.0
module tb_optical_switch_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] grant = '0;
  logic        grant_valid = 1'b0;
  logic        sclk, sdata, latch, busy, cfg_done, ovw;
  logic [19:0] applied;

  int tests_run    = 0;
  int tests_failed = 0;

  // Stimulus schedule: grant pulses at relative cycles, optional one-cycle reset.
  int          sch_n;
  int          sch_c[8];
  logic [19:0] sch_w[8];
  int          rst_at;

  // Per-run observations.
  int          rise_n, latch_n, latch_first, done_n, ovw_n, sd_viol, sclk_in_latch;
  int          rise_cyc[64];
  logic        bits[64];
  int          done_cyc[8];
  logic [19:0] done_word[8];
  int          ovw_cyc[8];
  logic        busy_tr[512];
  logic [5:0]  snap_ctl;
  logic [19:0] snap_app;

  optical_switch_driver #(
    .P_GRANTWIDTH    (20),
    .P_CLKDIV        (2),
    .P_LATCH_CYCLES  (2),
    .P_SETTLE_CYCLES (10)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_grant         (grant),
    .i_grant_valid   (grant_valid),
    .o_sw_sclk       (sclk),
    .o_sw_sdata      (sdata),
    .o_sw_latch      (latch),
    .o_busy          (busy),
    .o_config_done   (cfg_done),
    .o_applied_grant (applied),
    .o_overwrite     (ovw)
  );

  always #5 clk = ~clk;

  task automatic drive(input int t);
    grant_valid = 1'b0;
    grant       = '0;
    for (int j = 0; j < sch_n; j++) begin
      if (sch_c[j] == t) begin
        grant_valid = 1'b1;
        grant       = sch_w[j];
      end
    end
    rst = (rst_at >= 0) && (t == rst_at);
  endtask

  task automatic run(input int n);
    int   t;
    logic prev_sclk, prev_sdata;
    rise_n = 0; latch_n = 0; latch_first = -1; done_n = 0; ovw_n = 0;
    sd_viol = 0; sclk_in_latch = 0; snap_ctl = '1; snap_app = '1;
    prev_sclk = sclk; prev_sdata = sdata;
    t = 0;
    drive(0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      t++;
      if (t < 512) busy_tr[t] = busy;
      if (sclk && !prev_sclk && rise_n < 64) begin
        rise_cyc[rise_n] = t;
        bits[rise_n]     = sdata;
        rise_n++;
      end
      if (sclk && (sdata !== prev_sdata)) sd_viol++;
      if (latch) begin
        if (latch_n == 0) latch_first = t;
        latch_n++;
        if (sclk) sclk_in_latch++;
      end
      if (cfg_done && done_n < 8) begin
        done_cyc[done_n]  = t;
        done_word[done_n] = applied;
        done_n++;
      end
      if (ovw && ovw_n < 8) begin
        ovw_cyc[ovw_n] = t;
        ovw_n++;
      end
      if (t == rst_at + 1) begin
        snap_ctl = {sclk, sdata, latch, busy, cfg_done, ovw};
        snap_app = applied;
      end
      prev_sclk  = sclk;
      prev_sdata = sdata;
      drive(t);
    end
    sch_n = 0; rst_at = -1;
    drive(-1);
  endtask

  function automatic logic [19:0] bits_word(input int base);
    logic [19:0] w;
    w = '0;
    for (int i = 0; i < 20; i++) w = {w[18:0], bits[base+i]};
    return w;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if ({sclk, sdata, latch, busy, cfg_done, ovw} !== 6'b0) begin tests_failed++; $display("FAIL reset_ctl: got %b expected 000000", {sclk, sdata, latch, busy, cfg_done, ovw}); end
    tests_run++; if (applied !== 20'h0) begin tests_failed++; $display("FAIL reset_applied: got %h expected 00000", applied); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    sch_n = 1; sch_c[0] = 0; sch_w[0] = 20'hA5C3E; rst_at = -1;
    run(100);
    tests_run++; if (rise_n !== 20) begin tests_failed++; $display("FAIL single_rises: got %0d expected 20", rise_n); end
    tests_run++; if (rise_cyc[0] !== 3) begin tests_failed++; $display("FAIL single_first_rise: got %0d expected 3", rise_cyc[0]); end
    tests_run++; if (bits_word(0) !== 20'hA5C3E) begin tests_failed++; $display("FAIL single_sdata: got %h expected a5c3e", bits_word(0)); end
    tests_run++; if (sd_viol !== 0) begin tests_failed++; $display("FAIL single_sdata_while_high: got %0d expected 0", sd_viol); end
    tests_run++; if (latch_n !== 2 || latch_first !== 81) begin tests_failed++; $display("FAIL single_latch: got %0d@%0d expected 2@81", latch_n, latch_first); end
    tests_run++; if (sclk_in_latch !== 0) begin tests_failed++; $display("FAIL single_sclk_in_latch: got %0d expected 0", sclk_in_latch); end
    tests_run++; if (done_n !== 1 || done_cyc[0] !== 93) begin tests_failed++; $display("FAIL single_done: got %0d@%0d expected 1@93", done_n, done_cyc[0]); end
    tests_run++; if (done_word[0] !== 20'hA5C3E) begin tests_failed++; $display("FAIL single_applied: got %h expected a5c3e", done_word[0]); end
    tests_run++; if (busy_tr[1] !== 1'b1 || busy_tr[94] !== 1'b0) begin tests_failed++; $display("FAIL single_busy: got %b%b expected 10", busy_tr[1], busy_tr[94]); end
  endtask

  task automatic test_back_to_back;
    sch_n = 2; sch_c[0] = 0; sch_w[0] = 20'h00001; sch_c[1] = 10; sch_w[1] = 20'hFFFFF; rst_at = -1;
    run(195);
    tests_run++; if (done_n !== 2 || done_cyc[0] !== 93 || done_cyc[1] !== 186) begin tests_failed++; $display("FAIL b2b_done: got %0d@%0d,%0d expected 2@93,186", done_n, done_cyc[0], done_cyc[1]); end
    tests_run++; if (rise_cyc[20] !== 96) begin tests_failed++; $display("FAIL b2b_second_start: got %0d expected 96", rise_cyc[20]); end
    tests_run++; if (bits_word(0) !== 20'h00001 || bits_word(20) !== 20'hFFFFF) begin tests_failed++; $display("FAIL b2b_sdata: got %h,%h expected 00001,fffff", bits_word(0), bits_word(20)); end
    tests_run++; if (done_word[0] !== 20'h00001 || done_word[1] !== 20'hFFFFF) begin tests_failed++; $display("FAIL b2b_applied: got %h,%h expected 00001,fffff", done_word[0], done_word[1]); end
    tests_run++; if (ovw_n !== 0) begin tests_failed++; $display("FAIL b2b_overwrite: got %0d expected 0", ovw_n); end
  endtask

  task automatic test_overwrite;
    sch_n = 3; sch_c[0] = 0; sch_w[0] = 20'h11111; sch_c[1] = 5; sch_w[1] = 20'h22222;
    sch_c[2] = 6; sch_w[2] = 20'h33333; rst_at = -1;
    run(195);
    tests_run++; if (ovw_n !== 1 || ovw_cyc[0] !== 7) begin tests_failed++; $display("FAIL ovw_pulse: got %0d@%0d expected 1@7", ovw_n, ovw_cyc[0]); end
    tests_run++; if (rise_n !== 40 || bits_word(20) !== 20'h33333) begin tests_failed++; $display("FAIL ovw_second_sdata: got %0d/%h expected 40/33333", rise_n, bits_word(20)); end
    tests_run++; if (done_n !== 2 || done_word[1] !== 20'h33333 || done_cyc[1] !== 186) begin tests_failed++; $display("FAIL ovw_applied: got %0d/%h@%0d expected 2/33333@186", done_n, done_word[1], done_cyc[1]); end
  endtask

  task automatic test_done_arrival;
    sch_n = 2; sch_c[0] = 0; sch_w[0] = 20'h5A5A5; sch_c[1] = 93; sch_w[1] = 20'h5A5A5; rst_at = -1;
    run(195);
    tests_run++; if (rise_cyc[20] !== 96) begin tests_failed++; $display("FAIL done_arrival_start: got %0d expected 96", rise_cyc[20]); end
    tests_run++; if (busy_tr[94] !== 1'b1) begin tests_failed++; $display("FAIL done_arrival_busy: got %b expected 1", busy_tr[94]); end
    tests_run++; if (rise_n !== 40 || bits_word(20) !== 20'h5A5A5) begin tests_failed++; $display("FAIL identical_reshift: got %0d/%h expected 40/5a5a5", rise_n, bits_word(20)); end
    tests_run++; if (done_n !== 2 || done_cyc[1] !== 186 || ovw_n !== 0) begin tests_failed++; $display("FAIL done_arrival_done: got %0d@%0d ovw %0d expected 2@186 ovw 0", done_n, done_cyc[1], ovw_n); end
  endtask

  task automatic test_reset_mid_shift;
    sch_n = 2; sch_c[0] = 0; sch_w[0] = 20'hFFFFF; sch_c[1] = 45; sch_w[1] = 20'h0F0F0; rst_at = 40;
    run(150);
    tests_run++; if (snap_ctl !== 6'b0) begin tests_failed++; $display("FAIL midrst_ctl: got %b expected 000000", snap_ctl); end
    tests_run++; if (snap_app !== 20'h0) begin tests_failed++; $display("FAIL midrst_applied: got %h expected 00000", snap_app); end
    tests_run++; if (latch_n !== 2 || latch_first !== 126) begin tests_failed++; $display("FAIL midrst_latch: got %0d@%0d expected 2@126", latch_n, latch_first); end
    tests_run++; if (done_n !== 1 || done_cyc[0] !== 138 || done_word[0] !== 20'h0F0F0) begin tests_failed++; $display("FAIL midrst_done: got %0d@%0d/%h expected 1@138/0f0f0", done_n, done_cyc[0], done_word[0]); end
    tests_run++; if (rise_n !== 30 || bits_word(10) !== 20'h0F0F0) begin tests_failed++; $display("FAIL midrst_sdata: got %0d/%h expected 30/0f0f0", rise_n, bits_word(10)); end
  endtask

  initial begin
    sch_n = 0; rst_at = -1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overwrite();
    test_done_arrival();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/optical_switch_driver.md
OPTICAL_SWITCH_DRIVER -- requirements
Module: optical_switch_driver

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- P_GRANTWIDTH, 20, switch-config word width.
- P_CLKDIV, 2, i_clk cycles per o_sw_sclk half-period.
- P_LATCH_CYCLES, 2, o_sw_latch high time.
- P_SETTLE_CYCLES, 10, optical settle wait after latch.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- i_clk, in, 1, sole clock.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_grant, in, P_GRANTWIDTH, 8x8 switch configuration word from the 8x8 controller.
- i_grant_valid, in, 1, single-cycle qualifier for i_grant.
- o_sw_sclk, out, 1, serial clock to the switch-driver shift registers.
- o_sw_sdata, out, 1, serial data, MSB first.
- o_sw_latch, out, 1, parallel-load strobe to the switch drivers.
- o_busy, out, 1, high in any state other than IDLE.
- o_config_done, out, 1, single-cycle pulse when the new configuration has settled.
- o_applied_grant, out, P_GRANTWIDTH, last fully applied configuration.
- o_overwrite, out, 1, single-cycle pulse when a pending word is replaced.

Function
REQ-003 The FSM SHALL have states IDLE, SHIFT, LATCH, SETTLE, DONE.
REQ-004 In IDLE, i_grant_valid=1 SHALL capture i_grant into the shift register and enter SHIFT on the next edge.
REQ-005 In SHIFT, each bit SHALL take 2*P_CLKDIV cycles: sclk low for P_CLKDIV cycles, then high for P_CLKDIV cycles.
REQ-006 o_sw_sdata SHALL change only while sclk is low, at the start of each bit period; bit P_GRANTWIDTH-1 is sent first.
REQ-007 After the last bit's high phase, the FSM SHALL enter LATCH with sclk=0.
REQ-008 In LATCH, o_sw_latch SHALL be high for exactly P_LATCH_CYCLES cycles; the FSM then enters SETTLE.
REQ-009 The FSM SHALL remain in SETTLE for exactly P_SETTLE_CYCLES cycles, then enter DONE.
REQ-010 DONE SHALL last one cycle: o_config_done=1, and o_applied_grant updates to the shifted word on the same edge.
REQ-011 From DONE, the FSM SHALL go to SHIFT with the pending word if the pending buffer is full (and clear the buffer); otherwise it goes to IDLE.
REQ-012 Latency from the accepting edge to o_config_done high SHALL be 1 + 2*P_CLKDIV*P_GRANTWIDTH + P_LATCH_CYCLES + P_SETTLE_CYCLES cycles.
REQ-013 i_grant_valid while o_busy=1 SHALL write a one-deep pending buffer; the latest word wins.
REQ-014 If the pending buffer was already full on that write, o_overwrite SHALL pulse for one cycle.
REQ-015 i_grant_valid in DONE SHALL be treated as a pending write and launched by REQ-011 on the same edge.
REQ-016 Bit and phase counters SHALL be sized $clog2(P_GRANTWIDTH) and $clog2(max(P_CLKDIV, P_LATCH_CYCLES, P_SETTLE_CYCLES)+1); counters SHALL NOT wrap.
REQ-017 Identical consecutive words SHALL still be fully reshifted; there is no skip optimisation.

Reset
REQ-018 While i_rst=1, the following SHALL hold:
- State is IDLE.
- All outputs are 0, including o_applied_grant (all switches BAR).
- The pending buffer is empty and all counters are 0.
REQ-019 Reset mid-transfer SHALL abort the transfer without a latch pulse or a done pulse.

Structure
REQ-020 State encodings and the P_BAR/P_CROSS constants SHALL live in the shared optical-control package.
REQ-021 One sub-module, optical_sclk_gen, SHALL produce the divided sclk and the bit-advance strobe.
REQ-022 All outputs SHALL be registered.

Verification (P_CLKDIV=2, P_LATCH_CYCLES=2, P_SETTLE_CYCLES=10, P_GRANTWIDTH=20; latency 93)
REQ-023 Single config: i_grant=20'hA5C3E pulsed at cycle 0 -> 20 sclk rising edges, sdata samples 1010_0101_1100_0011_1110, latch high for 2 cycles, o_config_done at cycle 93, o_applied_grant=20'hA5C3E.
REQ-024 Back-to-back: 20'h00001 at cycle 0, 20'hFFFFF at cycle 10 -> first done at cycle 93, second shift starts at cycle 94, second done at cycle 186, no overwrite.
REQ-025 Overwrite: pulses 20'h11111 at cycle 0, 20'h22222 at cycle 5, 20'h33333 at cycle 6 -> o_overwrite at cycle 7, second applied word 20'h33333, 20'h22222 never shifted.
REQ-026 Reset mid-shift: i_rst at cycle 40 -> all outputs 0 next cycle, no latch or done; a new grant after release completes in 93 cycles.
REQ-027 DONE-cycle arrival: valid asserted exactly at cycle 93 -> next shift begins at cycle 94 with no idle gap.
